// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline stage register.
// Captures a WIDTH-bit payload and a valid bit on the falling edge of clk,
// honours stall/flush from the hazard unit, tracks occupancy in a small FSM
// and counts consecutive stalled edges so a stuck stage can be detected.
// Optional feature macro: PIPE_STAGE_REG_PERF_EN adds perf_stalls and
// perf_flushes event counters (cleared only by rst, wrap modulo 2^32).
module pipe_stage_reg #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0,
  parameter int unsigned      STALL_LIMIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid_out,
  output logic [7:0]       stall_cnt,
  output logic             stall_timeout,
  output logic [1:0]       state
`ifdef PIPE_STAGE_REG_PERF_EN
  ,
  output logic [31:0]      perf_stalls,
  output logic [31:0]      perf_flushes
`endif
);

  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    FULL    = 2'b01,
    HELD    = 2'b10,
    TIMEOUT = 2'b11
  } state_t;

  localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

  state_t     state_r;
  logic [7:0] cnt_inc;
  logic       timeout_next;

  assign state = state_r;

  // Saturating increment of the stall counter and the limit comparison it feeds.
  always_comb begin
    cnt_inc      = (stall_cnt == 8'hFF) ? 8'hFF : stall_cnt + 8'd1;
    timeout_next = (cnt_inc >= LIMIT);
  end

  // Payload, valid, stall counter and FSM state; priority rst > flush > stall > load.
  // NOTE: every register here updates with <= so all of them see the pre-edge
  // values of one another; a blocking = would let later lines read new values.
  always_ff @(negedge clk) begin
    if (rst) begin
      q             <= RESET_VAL;
      valid_out     <= 1'b0;
      stall_cnt     <= 8'd0;
      stall_timeout <= 1'b0;
      state_r       <= EMPTY;
    end else if (flush) begin
      q             <= RESET_VAL;
      valid_out     <= 1'b0;
      stall_cnt     <= 8'd0;
      stall_timeout <= 1'b0;
      state_r       <= EMPTY;
    end else if (stall) begin
      // Contents hold; the state reports whether the limit has been reached.
      stall_cnt     <= cnt_inc;
      stall_timeout <= timeout_next;
      state_r       <= timeout_next ? TIMEOUT : HELD;
    end else begin
      q             <= d;
      valid_out     <= valid_in;
      stall_cnt     <= 8'd0;
      stall_timeout <= 1'b0;
      state_r       <= valid_in ? FULL : EMPTY;
    end
  end

`ifdef PIPE_STAGE_REG_PERF_EN
  // Event counters; a stall coinciding with a flush is counted as a flush only.
  always_ff @(negedge clk) begin
    if (rst) begin
      perf_stalls  <= 32'd0;
      perf_flushes <= 32'd0;
    end else if (flush) begin
      perf_flushes <= perf_flushes + 32'd1;
    end else if (stall) begin
      perf_stalls  <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register replacing the per-stage fixed-width capture blocks between fetch, decode, execute, memory and writeback. It captures a WIDTH-bit payload plus a valid bit on the falling edge of `clk`, honours stall and flush requests from the hazard unit, and tracks its own occupancy state. A stall-length counter flags stalls that exceed a programmed limit so the hazard unit or the bench can detect deadlock.

## Interface
- `WIDTH`, 32, payload width in bits (1..256).
- `RESET_VAL`, 0, value loaded into `q` on reset and flush (WIDTH bits).
- `STALL_LIMIT`, 16, consecutive stalled cycles before `stall_timeout` asserts (1..255).

- `clk`  input  1  stage clock; all state updates on the falling edge.
- `rst`  input  1  synchronous, active-high reset, sampled on the falling edge.
- `stall`  input  1  hold current contents.
- `flush`  input  1  replace contents with a bubble.
- `valid_in`  input  1  `d` carries a real instruction.
- `d`  input  WIDTH  payload from the previous stage.
- `q`  output  WIDTH  registered payload.
- `valid_out`  output  1  `q` is a real instruction.
- `stall_cnt`  output  8  consecutive stalled edges, saturating at 255.
- `stall_timeout`  output  1  `stall_cnt >= STALL_LIMIT`, registered.
- `state`  output  2  FSM state encoding, for debug.

## Operation
- Priority per falling edge: `rst` > `flush` > `stall` > load.
- Load: `q <= d`, `valid_out <= valid_in`.
- Stall: `q`, `valid_out` unchanged; `stall_cnt` increments, saturating at 255.
- Flush: `q <= RESET_VAL`, `valid_out <= 0`, `stall_cnt <= 0`; flush overrides a simultaneous stall.
- Any edge without stall clears `stall_cnt` to 0.
- `stall_timeout` is set on the edge where `stall_cnt` becomes `>= STALL_LIMIT`. It stays set while stalling and clears on the first non-stall edge.
- FSM states:
  - EMPTY (00): `valid_out=0`.
  - FULL (01): `valid_out=1`, advancing.
  - HELD (10): stalled; entered from FULL or EMPTY on `stall`.
  - TIMEOUT (11): HELD with `stall_timeout=1`.
- FSM transitions:
  - EMPTY/FULL → HELD on `stall`; otherwise → FULL if `valid_in`, else EMPTY.
  - HELD → TIMEOUT when the limit is reached.
  - HELD/TIMEOUT → FULL/EMPTY per `valid_in` on a non-stall load.
  - Flush from any state → EMPTY.
- Reset mid-stall: all state is cleared on that edge; there is no carry-over.

## Timing
- Reset values:
  - `q=RESET_VAL`, `valid_out=0`, `stall_cnt=0`, `stall_timeout=0`, `state=EMPTY`.
  - Perf counters are 0 (when compiled in).
- Latency: `d` appears on `q` one falling edge after capture, i.e. half a cycle after the rising edge that produced `d`.
- `stall` and `flush` must be stable before the falling edge. They are sampled only there, and there is no combinational path from any input to any output.
- `stall_timeout` asserts on the falling edge on which `stall_cnt` reaches `STALL_LIMIT`, i.e. after the `STALL_LIMIT`-th consecutive stalled edge.

## Configuration
- `PIPE_STAGE_REG_PERF_EN` defined: adds outputs `perf_stalls[31:0]` and `perf_flushes[31:0]`.
  - `perf_stalls` counts stalled edges; `perf_flushes` counts flush edges.
  - Both wrap modulo 2^32 and are cleared only by `rst`.
  - A simultaneous stall and flush counts as a flush only.
- Not defined: those ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset then load: `rst=1` for 2 edges, then `d=0x0040_0000`, `valid_in=1` → after 1 edge `q=0x0040_0000`, `valid_out=1`, `state=FULL`.
- Stall hold: load `0xAAAA_5555`, then `stall=1` for 3 edges with `d=0x1234_5678` → `q` stays `0xAAAA_5555`, `stall_cnt=3`, `state=HELD`.
- Timeout: `STALL_LIMIT=4`, stall 4 edges → `stall_timeout=1`, `state=TIMEOUT`. Release stall → `stall_timeout=0`, `stall_cnt=0`, `q=d`.
- Flush vs stall: `stall=1` and `flush=1` together → `q=RESET_VAL`, `valid_out=0`, `stall_cnt=0`, `state=EMPTY`. With the perf macro, `perf_flushes` increments by 1 and `perf_stalls` is unchanged.
- Reset mid-stall: stall 10 edges with `STALL_LIMIT=4`, then `rst=1` → all outputs at reset values on that edge.
- Saturation: `STALL_LIMIT=255`, stall 300 edges → `stall_cnt` holds 255 and `stall_timeout=1` from edge 255 onward.
